// File: rtl/seg_pkg.sv
// Shared constants, state type and digit helpers for the 4-digit scanner.
package seg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Select the nibble for a digit position; digit 0 is the least significant.
    function automatic logic [3:0] digit_nibble(input logic [15:0] disp,
                                                input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = disp[3:0];
            2'd1:    nib = disp[7:4];
            2'd2:    nib = disp[11:8];
            2'd3:    nib = disp[15:12];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Active-low anode pattern for one digit position.
    function automatic logic [3:0] an_active(input logic [1:0] idx);
        logic [3:0] an;
        case (idx)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            2'd3:    an = 4'b0111;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 is always shown so a zero value still reads "0".
    function automatic logic lz_blanked(input logic [15:0] disp,
                                        input logic [1:0]  idx,
                                        input logic        blank_lz);
        logic hit;
        case (idx)
            2'd1:    hit = (disp[15:4]  == 12'h000);
            2'd2:    hit = (disp[15:8]  == 8'h00);
            2'd3:    hit = (disp[15:12] == 4'h0);
            default: hit = 1'b0;
        endcase
        return blank_lz & hit;
    endfunction

endpackage

// File: rtl/seg_digit_scanner_refresh_timer.sv
// Slot timer: counts CLK_DIV cycles per digit slot and flags the slot wrap
// plus whether the upcoming cycle lies in the ghost-suppression window.
module refresh_timer #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic start,
    output logic cnt_wrap,
    output logic in_blank
);

    localparam int                CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W:0]    BLANK_LEN = (CNT_W + 1)'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             run_r;

    // The first edge after reset only arms the timer so that cnt=0 is
    // presented together with the registered outputs for cnt=0.
    assign start    = ~run_r;
    assign cnt_wrap = run_r & (cnt_r == CNT_LAST);
    // in_blank looks one cycle ahead so the owner can register its outputs
    // in step with the counter.
    assign in_blank = ({1'b0, cnt_next_s} < BLANK_LEN);

    // Next counter value: hold at zero until armed, then count and wrap.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!run_r) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and arm flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            run_r <= 1'b1;
            cnt_r <= cnt_next_s;
        end
    end

endmodule

// File: rtl/seg_digit_scanner.sv
// Multiplexed 4-digit 7-segment scanner: cycles the digit anodes, feeds the
// active nibble to an external decoder, blanks at slot start to suppress
// ghosting, optionally blanks leading zeros, and swaps in newly loaded
// values only at frame boundaries.
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic        en,
    output logic [3:0]  an,
    output logic        frame
);

    localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

    logic        start_s;
    logic        cnt_wrap_s;
    logic        in_blank_s;
    logic        frame_bnd_s;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_next_s;
    logic [15:0] shadow_r;
    logic [15:0] disp_r;
    logic [15:0] disp_next_s;
    logic        pending_r;

    logic [3:0]  an_r;
    logic [3:0]  an_next_s;
    logic        en_r;
    logic        en_next_s;
    logic [3:0]  bcd_r;
    logic [3:0]  bcd_next_s;
    logic        frame_r;
    logic        frame_next_s;

    refresh_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .cnt_wrap (cnt_wrap_s),
        .in_blank (in_blank_s)
    );

    // Last cycle of digit 3: the next cycle starts a new frame.
    assign frame_bnd_s = cnt_wrap_s & (idx_r == IDX_LAST);

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Slot state transitions: BLANK until the window closes, SHOW until wrap.
    always_comb begin
        state_next_s = state_r;
        if (start_s) begin
            state_next_s = BLANK;
        end else begin
            case (state_r)
                BLANK: begin
                    if (!in_blank_s) begin
                        state_next_s = SHOW;
                    end else begin
                        state_next_s = BLANK;
                    end
                end
                SHOW: begin
                    if (cnt_wrap_s && in_blank_s) begin
                        state_next_s = BLANK;
                    end else begin
                        state_next_s = SHOW;
                    end
                end
                default: state_next_s = BLANK;
            endcase
        end
    end

    // Digit index advances once per slot wrap and restarts at 0.
    always_comb begin
        idx_next_s = idx_r;
        if (start_s) begin
            idx_next_s = 2'd0;
        end else if (cnt_wrap_s) begin
            idx_next_s = idx_r + 2'd1;
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Displayed value changes only at the frame boundary so a frame never tears.
    always_comb begin
        disp_next_s = disp_r;
        if (frame_bnd_s && pending_r) begin
            disp_next_s = shadow_r;
        end else begin
            disp_next_s = disp_r;
        end
    end

    // Index, display and load-shadow registers; a load on the boundary cycle
    // lands in shadow and stays pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= 2'd0;
            disp_r    <= 16'h0000;
            shadow_r  <= 16'h0000;
            pending_r <= 1'b0;
        end else begin
            idx_r  <= idx_next_s;
            disp_r <= disp_next_s;
            if (load) begin
                shadow_r  <= value;
                pending_r <= 1'b1;
            end else if (frame_bnd_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Output values for the upcoming cycle, built from next-state values so
    // the registered outputs line up with the counter.
    always_comb begin
        an_next_s    = AN_OFF;
        en_next_s    = 1'b0;
        bcd_next_s   = 4'h0;
        frame_next_s = start_s | frame_bnd_s;
        case (state_next_s)
            BLANK: begin
                an_next_s  = AN_OFF;
                en_next_s  = 1'b0;
                bcd_next_s = 4'h0;
            end
            SHOW: begin
                an_next_s  = an_active(idx_next_s);
                bcd_next_s = digit_nibble(disp_next_s, idx_next_s);
                en_next_s  = ~lz_blanked(disp_next_s, idx_next_s, blank_lz);
            end
            default: begin
                an_next_s  = AN_OFF;
                en_next_s  = 1'b0;
                bcd_next_s = 4'h0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r    <= AN_OFF;
            en_r    <= 1'b0;
            bcd_r   <= 4'h0;
            frame_r <= 1'b0;
        end else begin
            an_r    <= an_next_s;
            en_r    <= en_next_s;
            bcd_r   <= bcd_next_s;
            frame_r <= frame_next_s;
        end
    end

    assign an    = an_r;
    assign en    = en_r;
    assign bcd   = bcd_r;
    assign frame = frame_r;

endmodule
